// File: rtl/datapath_pkg.sv
// Shared encodings for the datapath core: bus source codes, ALU ops,
// load-enable bit positions and memory FSM states.
package datapath_pkg;

  localparam logic [3:0] SRC_ZERO = 4'd0;
  localparam logic [3:0] SRC_PC   = 4'd1;
  localparam logic [3:0] SRC_AR   = 4'd2;
  localparam logic [3:0] SRC_DR   = 4'd3;
  localparam logic [3:0] SRC_TR   = 4'd4;
  localparam logic [3:0] SRC_R    = 4'd5;
  localparam logic [3:0] SRC_RA   = 4'd6;
  localparam logic [3:0] SRC_RB   = 4'd7;
  localparam logic [3:0] SRC_RC   = 4'd8;
  localparam logic [3:0] SRC_AC   = 4'd9;

  typedef enum logic [2:0] {
    ALU_NOP = 3'b000,
    ALU_ADD = 3'b001,
    ALU_SUB = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100,
    ALU_XOR = 3'b101,
    ALU_NOT = 3'b110,
    ALU_CLR = 3'b111
  } alu_op_e;

  localparam int CB_PC  = 0;
  localparam int CB_AR  = 1;
  localparam int CB_DR  = 2;
  localparam int CB_TR  = 3;
  localparam int CB_R   = 4;
  localparam int CB_RA  = 5;
  localparam int CB_RB  = 6;
  localparam int CB_RC  = 7;
  localparam int CB_AC  = 8;
  localparam int CB_OUT = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } mem_state_e;

endpackage

// File: rtl/datapath_if.sv
// Data-memory request/acknowledge bus between the datapath core (master)
// and the data memory (slave).
interface datapath_mem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/datapath_alu.sv
// Combinational ALU: a is the accumulator, b is the bus. Zero flag is
// taken from the result it produces.
module alu_unit
  import datapath_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);
  always_comb begin
    result = a;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
      ALU_CLR: result = '0;
      default: result = a;
    endcase
  end

  assign zero = (result == '0);
endmodule

// File: rtl/datapath_core.sv
// Register-transfer datapath executing one control word per clock, with a
// three-state FSM handling data-memory reads and writes.
module datapath_core
  import datapath_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        A_bus,
  input  logic [2:0]        ALU,
  input  logic [9:0]        C_bus,
  input  logic              LDIR,
  input  logic              PC_INC,
  input  logic              AC_INC,
  input  logic              RA_INC,
  input  logic              RB_INC,
  input  logic              RC_INC,
  input  logic              read,
  input  logic              write,
  output logic [5:0]        IR,
  output logic              busy,
  output logic              z_flag,
  output logic              err,
  output logic [DATA_W-1:0] out_reg,
  datapath_mem_if.master    mem
);
  logic [DATA_W-1:0] pc_q, ar_q, dr_q, tr_q, r_q, ra_q, rb_q, rc_q, ac_q, out_q;
  logic [DATA_W-1:0] pc_d, ar_d, dr_d, tr_d, r_d, ra_d, rb_d, rc_d, ac_d, out_d;
  logic [5:0]        ir_q, ir_d;
  logic              z_q, z_d, err_q, err_d, rd_q, rd_d, wr_q, wr_d;
  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] bus, alu_res;
  logic              alu_zero, exec;

  function automatic logic [DATA_W-1:0] inc(input logic [DATA_W-1:0] v);
    return v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    bus = '0;
    case (A_bus)
      SRC_PC:  bus = pc_q;
      SRC_AR:  bus = ar_q;
      SRC_DR:  bus = dr_q;
      SRC_TR:  bus = tr_q;
      SRC_R:   bus = r_q;
      SRC_RA:  bus = ra_q;
      SRC_RB:  bus = rb_q;
      SRC_RC:  bus = rc_q;
      SRC_AC:  bus = ac_q;
      default: bus = '0;
    endcase
  end

  alu_unit #(.DATA_W(DATA_W)) u_alu (
    .a      (ac_q),
    .b      (bus),
    .op     (alu_op_e'(ALU)),
    .result (alu_res),
    .zero   (alu_zero)
  );

  assign exec = (state_q == ST_IDLE);

  always_comb begin
    pc_d = pc_q; ar_d = ar_q; dr_d = dr_q; tr_d = tr_q; r_d = r_q;
    ra_d = ra_q; rb_d = rb_q; rc_d = rc_q; ac_d = ac_q; out_d = out_q;
    ir_d = ir_q; z_d = z_q; err_d = err_q; rd_d = rd_q; wr_d = wr_q;
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // Bus load beats increment on every register that has both.
        if (C_bus[CB_PC]) pc_d = bus; else if (PC_INC) pc_d = inc(pc_q);
        if (C_bus[CB_AR]) ar_d = bus;
        if (C_bus[CB_DR]) dr_d = bus;
        if (C_bus[CB_TR]) tr_d = bus;
        if (C_bus[CB_R])  r_d  = bus;
        if (C_bus[CB_RA]) ra_d = bus; else if (RA_INC) ra_d = inc(ra_q);
        if (C_bus[CB_RB]) rb_d = bus; else if (RB_INC) rb_d = inc(rb_q);
        if (C_bus[CB_RC]) rc_d = bus; else if (RC_INC) rc_d = inc(rc_q);
        if (C_bus[CB_OUT]) out_d = bus;
        if (ALU != ALU_NOP) begin
          ac_d = alu_res;
          z_d  = alu_zero;
        end else if (C_bus[CB_AC]) begin
          ac_d = bus;
        end else if (AC_INC) begin
          ac_d = inc(ac_q);
        end
        if (LDIR) ir_d = dr_q[5:0];
        if (read && write) begin
          err_d = 1'b1;
        end else if (read) begin
          rd_d    = 1'b1;
          state_d = ST_RD_WAIT;
        end else if (write) begin
          wr_d    = 1'b1;
          state_d = ST_WR_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (mem.mem_ready) begin
          dr_d    = mem.mem_rdata;
          rd_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_WR_WAIT: begin
        if (mem.mem_ready) begin
          wr_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0; ar_q <= '0; dr_q <= '0; tr_q <= '0; r_q <= '0;
      ra_q <= '0; rb_q <= '0; rc_q <= '0; ac_q <= '0; out_q <= '0;
      ir_q <= '0; z_q <= 1'b0; err_q <= 1'b0; rd_q <= 1'b0; wr_q <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      pc_q <= pc_d; ar_q <= ar_d; dr_q <= dr_d; tr_q <= tr_d; r_q <= r_d;
      ra_q <= ra_d; rb_q <= rb_d; rc_q <= rc_d; ac_q <= ac_d; out_q <= out_d;
      ir_q <= ir_d; z_q <= z_d; err_q <= err_d; rd_q <= rd_d; wr_q <= wr_d;
      state_q <= state_d;
    end
  end

  assign busy          = ~exec;
  assign IR            = ir_q;
  assign z_flag        = z_q;
  assign err           = err_q;
  assign out_reg       = out_q;
  assign mem.mem_addr  = ar_q[ADDR_W-1:0];
  assign mem.mem_wdata = dr_q;
  assign mem.mem_rd    = rd_q;
  assign mem.mem_wr    = wr_q;
endmodule

// File: tb/tb_datapath_core.sv
// Directed bench for datapath_core: register transfers, ALU, memory
// handshake, error flag, priorities and asynchronous reset.
module tb_datapath_core;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] A_bus;
  logic [2:0] ALU;
  logic [9:0] C_bus;
  logic       LDIR, PC_INC, AC_INC, RA_INC, RB_INC, RC_INC, read, write;
  logic [5:0] IR;
  logic       busy, z_flag, err;
  logic [7:0] out_reg;
  logic [7:0] tb_mem [256];
  int         checks = 0;
  int         failures = 0;

  datapath_mem_if #(.DATA_W(8), .ADDR_W(8)) mif ();

  datapath_core #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .A_bus(A_bus), .ALU(ALU), .C_bus(C_bus),
    .LDIR(LDIR), .PC_INC(PC_INC), .AC_INC(AC_INC), .RA_INC(RA_INC),
    .RB_INC(RB_INC), .RC_INC(RC_INC), .read(read), .write(write),
    .IR(IR), .busy(busy), .z_flag(z_flag), .err(err), .out_reg(out_reg),
    .mem(mif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_ctrl();
    A_bus = 4'd0; ALU = 3'b000; C_bus = 10'h000; LDIR = 1'b0;
    PC_INC = 1'b0; AC_INC = 1'b0; RA_INC = 1'b0; RB_INC = 1'b0;
    RC_INC = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic move(input logic [3:0] src, input logic [9:0] loads);
    A_bus = src; C_bus = loads;
    step();
    clear_ctrl();
  endtask

  task automatic show(input logic [3:0] src);
    move(src, 10'h200);
  endtask

  // Issue one access, then hold for 'delay' busy cycles, acknowledging in the last.
  task automatic mem_cycle(input bit is_wr, input int delay, input bit poke,
                           input logic [7:0] exp_addr, input logic [7:0] exp_wd);
    if (is_wr) write = 1'b1; else read = 1'b1;
    step();
    clear_ctrl();
    for (int i = 0; i < delay; i++) begin
      check("busy_wait", busy, 1'b1);
      check("strobe_held", is_wr ? mif.mem_wr : mif.mem_rd, 1'b1);
      check("addr_hold", mif.mem_addr, exp_addr);
      if (is_wr) check("wdata_hold", mif.mem_wdata, exp_wd);
      if (poke) begin
        A_bus = 4'd0; C_bus = 10'h3FF; PC_INC = 1'b1; ALU = 3'b111;
      end
      if (i == delay - 1) begin
        mif.mem_ready = 1'b1;
        if (is_wr) tb_mem[exp_addr] = exp_wd;
        else mif.mem_rdata = tb_mem[exp_addr];
      end
      step();
      mif.mem_ready = 1'b0;
      clear_ctrl();
    end
    check("busy_done", busy, 1'b0);
    check("strobe_drop", {mif.mem_rd, mif.mem_wr}, 2'b00);
  endtask

  task automatic set_dr(input logic [7:0] v);
    move(4'd0, 10'h002);
    tb_mem[0] = v;
    mem_cycle(1'b0, 1, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_ctrl();
    mif.mem_ready = 1'b0;
    mif.mem_rdata = 8'h00;
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
    #2;
    check("rst_ir", IR, 6'h00);
    check("rst_out", out_reg, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_rd", mif.mem_rd, 1'b0);
    check("rst_z_err", {z_flag, err}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // PC to 5, then PC->AR with simultaneous increment
    for (int i = 0; i < 5; i++) begin
      PC_INC = 1'b1;
      step();
    end
    clear_ctrl();
    A_bus = 4'd1; C_bus = 10'h002; PC_INC = 1'b1;
    step();
    clear_ctrl();
    check("ar_from_pc", mif.mem_addr, 8'h05);
    show(4'd1);
    check("pc_inc", out_reg, 8'h06);

    // ALU subtract to zero, INC keeps z, then ADD clears z
    set_dr(8'h10);
    move(4'd3, 10'h120);
    A_bus = 4'd6; ALU = 3'b010;
    step();
    clear_ctrl();
    check("sub_z", z_flag, 1'b1);
    show(4'd9);
    check("sub_ac", out_reg, 8'h00);
    AC_INC = 1'b1;
    step();
    clear_ctrl();
    show(4'd9);
    check("ac_inc", out_reg, 8'h01);
    check("inc_keeps_z", z_flag, 1'b1);
    A_bus = 4'd6; ALU = 3'b001;
    step();
    clear_ctrl();
    show(4'd9);
    check("add_ac", out_reg, 8'h11);
    check("add_z", z_flag, 1'b0);

    // Read with 3 busy cycles; control word pushed during busy must be ignored
    set_dr(8'h20);
    move(4'd3, 10'h002);
    check("ar_20", mif.mem_addr, 8'h20);
    tb_mem[8'h20] = 8'h2B;
    mem_cycle(1'b0, 3, 1'b1, 8'h20, 8'h00);
    check("busy_ignored_out", out_reg, 8'h11);
    check("busy_ignored_z", z_flag, 1'b0);
    show(4'd3);
    check("read_dr", out_reg, 8'h2B);
    LDIR = 1'b1;
    step();
    clear_ctrl();
    check("ldir", IR, 6'b101011);
    show(4'd1);
    check("busy_ignored_pc", out_reg, 8'h06);

    // Write, then read/write conflict
    set_dr(8'hA5);
    mem_cycle(1'b1, 2, 1'b0, 8'h00, 8'hA5);
    check("no_err_yet", err, 1'b0);
    read = 1'b1; write = 1'b1;
    step();
    clear_ctrl();
    check("conflict_err", err, 1'b1);
    check("conflict_no_strobe", {mif.mem_rd, mif.mem_wr, busy}, 3'b000);
    step();
    check("err_sticky", err, 1'b1);

    // Wrap and priorities
    set_dr(8'hFF);
    move(4'd3, 10'h040);
    RB_INC = 1'b1;
    step();
    clear_ctrl();
    show(4'd7);
    check("rb_wrap", out_reg, 8'h00);
    A_bus = 4'd3; C_bus = 10'h101; ALU = 3'b111; PC_INC = 1'b1;
    step();
    clear_ctrl();
    show(4'd9);
    check("alu_over_load", out_reg, 8'h00);
    check("clr_z", z_flag, 1'b1);
    show(4'd1);
    check("load_over_inc", out_reg, 8'hFF);

    // Asynchronous reset in the middle of a read
    read = 1'b1;
    step();
    clear_ctrl();
    check("mid_rd_up", mif.mem_rd, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_mem_rd", mif.mem_rd, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_ir_out", {IR, out_reg}, 14'h0);
    check("arst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mif.mem_rdata = 8'h77;
    mif.mem_ready = 1'b1;
    step();
    mif.mem_ready = 1'b0;
    show(4'd3);
    check("stale_ready_ignored", out_reg, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
